// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory responder
package dmem_pkg;

  // Responder transaction phases
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int DEPTH_DEFAULT       = 8192;
  localparam int WAIT_CYCLES_DEFAULT = 2;
  // Number of word-index bits taken from the byte address for the default depth
  localparam int IDX_W_DEFAULT       = $clog2(DEPTH_DEFAULT);

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - valid/ready request/response bus between core and data memory
interface dmem_responder_if #(
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word RAM with registered read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic                     clock,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One access per enabled edge: write, or capture the addressed word into rdata
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder; DMEM_ALIGN_CHECK_EN rejects misaligned addresses
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  dmem_responder_if.slave  bus,
  output logic             busy
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic              we_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_err_q;
  logic              rsp_zero_q;
  logic [DATA_W-1:0] arr_rdata;

  logic              accept;
  logic              enter_resp;
  logic              misalign;
  logic              live_err;
  logic              cur_we;
  logic              cur_err;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_wdata;
  logic              arr_en;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = |bus.req_addr[1:0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.req_addr[1:0];
  assign misalign        = 1'b0;
`endif

  assign live_err = (|bus.req_addr[31:IDX_W+2]) | misalign;

  // Gated by reset_n so the initiator never sees ready while reset is held
  assign bus.req_ready = (state == IDLE) & reset_n;
  assign accept        = bus.req_valid & bus.req_ready;

  // With zero wait states RESP is entered on the accepting edge, before the latch is loaded
  assign cur_we    = (state == IDLE) ? bus.req_we                  : we_q;
  assign cur_err   = (state == IDLE) ? live_err                    : err_q;
  assign cur_idx   = (state == IDLE) ? bus.req_addr[IDX_W+1:2]     : idx_q;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata               : wdata_q;

  // Next-state decode for the IDLE/WAIT/RESP transaction sequence
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state_next == RESP) && (state != RESP);
  // Reset in WAIT must not let the abandoned store reach the array
  assign arr_en     = enter_resp & reset_n & ~cur_err;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Wait-state counter: loaded at acceptance, counts down while in WAIT
  always_ff @(posedge clock) begin
    if (!reset_n)                          cnt <= 4'd0;
    else if (accept)                       cnt <= WAIT_LOAD;
    else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // Request latch captured at acceptance
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      err_q   <= live_err;
      idx_q   <= bus.req_addr[IDX_W+1:2];
      wdata_q <= bus.req_wdata;
    end
  end

  // Response flags: error, and whether the read data must be forced to zero
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rsp_err_q  <= 1'b0;
      rsp_zero_q <= 1'b1;
    end else if (enter_resp) begin
      rsp_err_q  <= cur_err;
      rsp_zero_q <= cur_we | cur_err;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clock (clock),
    .en    (arr_en),
    .we    (cur_we),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_zero_q ? '0 : arr_rdata;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (WAIT_CYCLES=2 and 0 instances)
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dmem_responder_if #(.DATA_W(32)) bus2 ();
  dmem_responder_if #(.DATA_W(32)) bus0 ();
  logic busy2, busy0;

  dmem_responder #(.DATA_W(32), .DEPTH(8192), .WAIT_CYCLES(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(bus2), .busy(busy2));
  dmem_responder #(.DATA_W(32), .DEPTH(8192), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0), .busy(busy0));

  logic        sel = 1'b0;
  logic        t_valid = 1'b0, t_we = 1'b0, t_rready = 1'b0;
  logic [31:0] t_addr = '0, t_wdata = '0;

  assign bus2.req_valid = t_valid & ~sel;
  assign bus2.req_we    = t_we;
  assign bus2.req_addr  = t_addr;
  assign bus2.req_wdata = t_wdata;
  assign bus2.rsp_ready = t_rready & ~sel;
  assign bus0.req_valid = t_valid & sel;
  assign bus0.req_we    = t_we;
  assign bus0.req_addr  = t_addr;
  assign bus0.req_wdata = t_wdata;
  assign bus0.rsp_ready = t_rready & sel;

  wire        o_rdy   = sel ? bus0.req_ready : bus2.req_ready;
  wire        o_rv    = sel ? bus0.rsp_valid : bus2.rsp_valid;
  wire [31:0] o_rdata = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
  wire        o_err   = sel ? bus0.rsp_err   : bus2.rsp_err;
  wire        o_busy  = sel ? busy0 : busy2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m2 [8192];
  logic [31:0] m0 [8192];

  function automatic int cur_w();
    return sel ? 0 : 2;
  endfunction

  function automatic logic [31:0] model_rd(input int idx);
    return sel ? m0[idx] : m2[idx];
  endfunction

  task automatic model_wr(input int idx, input logic [31:0] d);
    if (sel) m0[idx] = d;
    else     m2[idx] = d;
  endtask

  function automatic logic model_err(input logic [31:0] a);
    return (a[31:15] != 17'd0) || (ALIGN && a[1:0] != 2'd0);
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // One full transaction: accept, latency, optional stall, release. Starts and ends at a negedge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int stall);
    logic        e_err;
    logic [31:0] e_rdata;
    int          idx;
    idx     = int'(addr[14:2]);
    e_err   = model_err(addr);
    e_rdata = (we || e_err) ? 32'd0 : model_rd(idx);
    n_checks++;
    if (o_rdy !== 1'b1) $display("FAIL idle_ready: got %b expected 1", o_rdy);
    else n_pass++;
    t_valid = 1'b1; t_we = we; t_addr = addr; t_wdata = wdata; t_rready = 1'b0;
    @(posedge clock);
    #1;
    t_valid = 1'b0; t_we = $urandom_range(0, 1); t_addr = $urandom; t_wdata = $urandom;
    if (we && !e_err) model_wr(idx, wdata);
    for (int k = 0; k <= cur_w(); k++) begin
      @(negedge clock);
      if (k < cur_w()) begin
        n_checks++;
        if ({o_rv, o_busy, o_rdy} !== 3'b010)
          $display("FAIL wait_phase k=%0d: got valid/busy/ready=%b expected 010", k, {o_rv, o_busy, o_rdy});
        else n_pass++;
      end else begin
        n_checks++;
        if (o_rv !== 1'b1) $display("FAIL rsp_latency: got rsp_valid=%b expected 1", o_rv);
        else n_pass++;
        n_checks++;
        if (o_rdata !== e_rdata) $display("FAIL rsp_rdata addr=%h: got %h expected %h", addr, o_rdata, e_rdata);
        else n_pass++;
        n_checks++;
        if (o_err !== e_err) $display("FAIL rsp_err addr=%h: got %b expected %b", addr, o_err, e_err);
        else n_pass++;
      end
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      n_checks++;
      if ({o_rv, o_busy, o_rdy, o_err} !== {3'b110, e_err} || o_rdata !== e_rdata)
        $display("FAIL stall_hold s=%0d: got v/b/r/e=%b data=%h expected %b data=%h",
                 s, {o_rv, o_busy, o_rdy, o_err}, o_rdata, {3'b110, e_err}, e_rdata);
      else n_pass++;
    end
    t_rready = 1'b1;
    @(negedge clock);
    t_rready = 1'b0;
    n_checks++;
    if ({o_rv, o_busy, o_rdy} !== 3'b001)
      $display("FAIL release: got valid/busy/ready=%b expected 001", {o_rv, o_busy, o_rdy});
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      n_checks++;
      if ({o_rdy, o_rv, o_busy, o_err} !== 4'b0000 || o_rdata !== 32'd0)
        $display("FAIL reset_held sel=%0d: got r/v/b/e=%b data=%h expected 0000 data=0", s, {o_rdy, o_rv, o_busy, o_err}, o_rdata);
      else n_pass++;
    end
    reset_n = 1'b1;
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      n_checks++;
      if ({o_rdy, o_rv, o_busy, o_err} !== 4'b1000 || o_rdata !== 32'd0)
        $display("FAIL reset_release sel=%0d: got r/v/b/e=%b data=%h expected 1000 data=0", s, {o_rdy, o_rv, o_busy, o_err}, o_rdata);
      else n_pass++;
    end
    sel = 1'b0;
  endtask

  task automatic preload();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 16; i++) txn(1'b1, 32'(i * 4), $urandom, 0);
    end
    sel = 1'b0;
  endtask

  task automatic test_store_load();
    sel = 1'b0;
    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    txn(1'b0, 32'h0000_0010, 32'd0, 0);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    txn(1'b0, 32'h0000_0010, 32'd0, 5);
  endtask

  task automatic test_out_of_range();
    sel = 1'b0;
    txn(1'b1, 32'h0000_0000, 32'hA5A5_0001, 0);
    txn(1'b0, 32'h0000_8000, 32'd0, 0);
    txn(1'b1, 32'h0000_8000, 32'h0000_FFFF, 0);
    txn(1'b0, 32'h0000_0000, 32'd0, 0);
  endtask

  task automatic test_reset_mid_wait();
    sel = 1'b0;
    txn(1'b1, 32'h0000_0020, 32'hCAFE_0020, 0);
    t_valid = 1'b1; t_we = 1'b1; t_addr = 32'h20; t_wdata = 32'h1234_5678;
    @(posedge clock);
    #1;
    t_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({o_busy, o_rv} !== 2'b00) $display("FAIL mid_wait_busy: got busy/valid=%b expected 00", {o_busy, o_rv});
    else n_pass++;
    txn(1'b0, 32'h0000_0020, 32'd0, 0);
  endtask

  task automatic test_reset_mid_resp();
    sel = 1'b0;
    t_valid = 1'b1; t_we = 1'b1; t_addr = 32'h24; t_wdata = 32'h55AA_0024;
    @(posedge clock);
    #1;
    t_valid = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (o_rv !== 1'b1) $display("FAIL mid_resp_valid: got %b expected 1", o_rv);
    else n_pass++;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    model_wr(9, 32'h55AA_0024);
    @(negedge clock);
    n_checks++;
    if ({o_busy, o_rv} !== 2'b00) $display("FAIL mid_resp_busy: got busy/valid=%b expected 00", {o_busy, o_rv});
    else n_pass++;
    txn(1'b0, 32'h0000_0024, 32'd0, 0);
  endtask

  task automatic test_align();
    sel = 1'b0;
    txn(1'b0, 32'h0000_0013, 32'd0, 0);
    txn(1'b1, 32'h0000_0016, 32'h0BAD_F00D, 0);
    txn(1'b0, 32'h0000_0014, 32'd0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    int          acc_edges [$];
    logic        prev_acc;
    int          ai;
    sel = 1'b1;
    addrs[0] = 32'h04; addrs[1] = 32'h18; addrs[2] = 32'h2C; addrs[3] = 32'h3C;
    prev_acc = 1'b0;
    ai = 0;
    t_rready = 1'b1; t_we = 1'b0; t_valid = 1'b1; t_addr = addrs[0];
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        n_checks++;
        if (o_rv !== prev_acc) $display("FAIL b2b_valid c=%0d: got %b expected %b", c, o_rv, prev_acc);
        else n_pass++;
        if (prev_acc) begin
          n_checks++;
          if (o_rdata !== model_rd(int'(addrs[ai-1][14:2])))
            $display("FAIL b2b_rdata c=%0d: got %h expected %h", c, o_rdata, model_rd(int'(addrs[ai-1][14:2])));
          else n_pass++;
        end
      end
      prev_acc = t_valid & o_rdy;
      if (prev_acc) acc_edges.push_back(c);
      @(posedge clock);
      #1;
      if (prev_acc) begin
        ai++;
        if (ai < 4) t_addr = addrs[ai];
        else t_valid = 1'b0;
      end
      @(negedge clock);
    end
    t_rready = 1'b0;
    n_checks++;
    if (acc_edges.size() != 4) $display("FAIL b2b_count: got %0d expected 4", acc_edges.size());
    else n_pass++;
    for (int i = 1; i < acc_edges.size(); i++) begin
      n_checks++;
      if (acc_edges[i] - acc_edges[i-1] != 2)
        $display("FAIL b2b_spacing i=%0d: got %0d expected 2", i, acc_edges[i] - acc_edges[i-1]);
      else n_pass++;
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 1);
      a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) a = a | (32'd1 << $urandom_range(15, 31));
      txn($urandom_range(0, 1), a, $urandom, $urandom_range(0, 3));
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    preload();
    test_store_load();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_wait();
    test_reset_mid_resp();
    test_align();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
